mux2_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the shared 2:1 mux datapath.
//  - Two requesters (A, B) compete for one output channel.
//  - The block owns the mux select, grants one requester at a time, and

---
 rtl/mux2_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux2_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 arbiter/sequencer owning the mux select; burst grant up to BURST_LEN words.
// Latency: 1 cycle req->gnt; data path is combinational once granted. Optional MUX_ARB_LOCK_EN adds lock_a/lock_b.
// Backpressure: out_ready=0 holds the grant and beat count indefinitely.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock_a,
  input  logic             lock_b,
`endif
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             xfer
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);

  state_t           state;
  state_t           nxt;
  state_t           same_st;
  state_t           other_st;
  logic [CNT_W-1:0] cnt;
  logic             prio;
  logic             owned;
  logic             own_b;
  logic             req_own;
  logic             req_oth;
  logic             lock_own;
  logic             burst_done;
  logic             dropped;
  logic             handover;
  logic             abandon;

  // Reset gates the handshake so a burst aborted by reset never completes a word.
  assign out_valid = rst_n & ((gnt_a & req_a) | (gnt_b & req_b));
  assign out_data  = sel ? data_b : data_a;
  assign xfer      = out_valid & out_ready;

  assign owned    = (state != IDLE);
  assign own_b    = (state == OWN_B);
  assign req_own  = own_b ? req_b : req_a;
  assign req_oth  = own_b ? req_a : req_b;
  assign same_st  = own_b ? OWN_B : OWN_A;
  assign other_st = own_b ? OWN_A : OWN_B;

`ifdef MUX_ARB_LOCK_EN
  assign lock_own = own_b ? lock_b : lock_a;
`else
  assign lock_own = 1'b0;
`endif

  // A drop after at least one word is a normal handover; a drop with no word moved is an abandon.
  assign burst_done = xfer & ~lock_own & (cnt >= CNT_LAST);
  assign dropped    = owned & ~req_own;
  assign handover   = burst_done | (dropped & (cnt != '0));
  assign abandon    = dropped & (cnt == '0);

  always_comb begin
    nxt = state;
    if (state == IDLE) begin
      if (req_a & req_b) nxt = prio ? OWN_B : OWN_A;
      else if (req_a)    nxt = OWN_A;
      else if (req_b)    nxt = OWN_B;
    end else if (abandon) begin
      nxt = IDLE;
    end else if (handover) begin
      if (req_oth)      nxt = other_st;
      else if (req_own) nxt = same_st;
      else              nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      sel   <= 1'b0;
      cnt   <= '0;
      prio  <= 1'b0;
    end else begin
      state <= nxt;
      gnt_a <= (nxt == OWN_A);
      gnt_b <= (nxt == OWN_B);
      if (nxt == OWN_A)      sel <= 1'b0;
      else if (nxt == OWN_B) sel <= 1'b1;
      if (handover | abandon) begin
        prio <= ~own_b;
        cnt  <= '0;
      end else if (xfer && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios then random traffic against a rule-level model.
module tb_mux2_rr_arbiter;
  localparam int WIDTH     = 8;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_a = 1'b0;
  logic             req_b = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] data_a = '0;
  logic [WIDTH-1:0] data_b = '0;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic             out_valid;
  logic             xfer;
  logic [WIDTH-1:0] out_data;
`ifdef MUX_ARB_LOCK_EN
  logic             lock_a = 1'b0;
  logic             lock_b = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Model: owner 0=none,1=A,2=B; pref is the requester that wins a tie.
  int   m_owner = 0;
  int   m_beats = 0;
  int   m_pref  = 1;
  logic m_sel   = 1'b0;

  int   hist[$];
  logic obs_xa = 1'b0;
  logic obs_xb = 1'b0;
  logic seen_gnt_b = 1'b0;
  int   n_cyc;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .out_ready(out_ready),
`ifdef MUX_ARB_LOCK_EN
    .lock_a(lock_a), .lock_b(lock_b),
`endif
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .xfer(xfer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    logic e_valid, e_xfer, mine, theirs, locked;
    int   other;
    @(negedge clk);
    e_valid = rst_n && ((m_owner == 1 && req_a) || (m_owner == 2 && req_b));
    e_xfer  = e_valid && out_ready;
    check("gnt_a", gnt_a, m_owner == 1);
    check("gnt_b", gnt_b, m_owner == 2);
    check("sel", sel, m_sel);
    check("out_valid", out_valid, e_valid);
    check("xfer", xfer, e_xfer);
    check("out_data", out_data, m_sel ? data_b : data_a);
    obs_xa = xfer & gnt_a;
    obs_xb = xfer & gnt_b;
    if (gnt_b) seen_gnt_b = 1'b1;
    if (xfer) hist.push_back(gnt_b ? 2 : 1);

    if (!rst_n) begin
      m_owner = 0; m_beats = 0; m_pref = 1; m_sel = 1'b0;
    end else if (m_owner == 0) begin
      if (req_a && req_b) m_owner = m_pref;
      else if (req_a)     m_owner = 1;
      else if (req_b)     m_owner = 2;
    end else begin
      other  = 3 - m_owner;
      mine   = (m_owner == 1) ? req_a : req_b;
      theirs = (m_owner == 1) ? req_b : req_a;
`ifdef MUX_ARB_LOCK_EN
      locked = (m_owner == 1) ? lock_a : lock_b;
`else
      locked = 1'b0;
`endif
      if (!mine) begin
        m_pref  = other;
        m_owner = (m_beats > 0 && theirs) ? other : 0;
        m_beats = 0;
      end else if (e_xfer) begin
        m_beats++;
        if (m_beats >= BURST_LEN && !locked) begin
          m_pref  = other;
          m_beats = 0;
          if (theirs) m_owner = other;
        end else if (m_beats > BURST_LEN) begin
          m_beats = BURST_LEN;
        end
      end
    end
    if (m_owner == 1)      m_sel = 1'b0;
    else if (m_owner == 2) m_sel = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = 1'b0; req_b = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset held two cycles with both requesting
    req_a = 1'b1; req_b = 1'b1;
    cycle(); cycle();
    check("rst_gnt_a", gnt_a, 1'b0);
    check("rst_gnt_b", gnt_b, 1'b0);
    check("rst_sel", sel, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    cycle();
    check("rst_release_gnt_a", gnt_a, 1'b1);
    do_reset();

    // Single requester, six words, grant renews after a full burst
    req_a = 1'b1; data_a = 8'h3C; out_ready = 1'b1;
    hist.delete(); seen_gnt_b = 1'b0; n_cyc = 0;
    for (int i = 0; i < 20 && hist.size() < 6; i++) begin
      cycle(); n_cyc++;
    end
    req_a = 1'b0;
    check("single_xfers", hist.size(), 6);
    check("single_cycles", n_cyc, 7);
    check("single_no_gnt_b", seen_gnt_b, 1'b0);
    do_reset();

    // Contention: alternating full bursts with no bubble
    req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
    hist.delete(); n_cyc = 0;
    for (int i = 0; i < 40 && hist.size() < 16; i++) begin
      cycle(); n_cyc++;
      if (obs_xa) data_a = WIDTH'($urandom);
      if (obs_xb) data_b = WIDTH'($urandom);
    end
    check("contend_cycles", n_cyc, 17);
    for (int i = 0; i < 16; i++) check("contend_order", hist[i], ((i / 4) % 2 == 0) ? 1 : 2);
    do_reset();

    // Backpressure while B owns mid-burst
    req_b = 1'b1; data_b = 8'hA5; out_ready = 1'b0;
    hist.delete();
    cycle();
    out_ready = 1'b1;
    cycle();
    data_b = 8'h5A; req_a = 1'b1; data_a = 8'h11; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("bp_xfers", hist.size(), 1);
    check("bp_gnt_b", gnt_b, 1'b1);
    check("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && hist.size() < 5; i++) cycle();
    for (int i = 0; i < 5; i++) check("bp_resume_order", hist[i], (i < 4) ? 2 : 1);
    do_reset();

    // Abandon then mid-burst reset
    req_a = 1'b1; out_ready = 1'b0;
    cycle();
    req_a = 1'b0; req_b = 1'b1;
    cycle();
    check("abandon_gnt_a", gnt_a, 1'b0);
    check("abandon_gnt_b", gnt_b, 1'b0);
    req_a = 1'b1;
    cycle();
    check("abandon_prio_b", gnt_b, 1'b1);
    check("abandon_sel", sel, 1'b1);
    out_ready = 1'b1;
    cycle();
    rst_n = 1'b0;
    cycle();
    check("midrst_gnt_b", gnt_b, 1'b0);
    check("midrst_sel", sel, 1'b0);
    rst_n = 1'b1;
    do_reset();

`ifdef MUX_ARB_LOCK_EN
    // Lock keeps A past the burst limit; release hands over after one more word
    req_a = 1'b1; req_b = 1'b1; lock_a = 1'b1; out_ready = 1'b1;
    hist.delete();
    cycle();
    for (int i = 0; i < 10; i++) cycle();
    check("lock_xfers", hist.size(), 10);
    check("lock_gnt_a", gnt_a, 1'b1);
    lock_a = 1'b0;
    cycle();
    check("unlock_xfers", hist.size(), 11);
    check("unlock_gnt_b", gnt_b, 1'b1);
    do_reset();
`endif

    // Random traffic obeying the requester hold rule
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_LOCK_EN
      lock_a = ($urandom_range(0, 3) == 0);
      lock_b = ($urandom_range(0, 3) == 0);
`endif
      if (!req_a) begin
        if ($urandom_range(0, 2) == 0) begin req_a = 1'b1; data_a = WIDTH'($urandom); end
      end else if (obs_xa) begin
        if ($urandom_range(0, 1) == 0) req_a = 1'b0;
        else data_a = WIDTH'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        req_a = 1'b0;
      end
      if (!req_b) begin
        if ($urandom_range(0, 2) == 0) begin req_b = 1'b1; data_b = WIDTH'($urandom); end
      end else if (obs_xb) begin
        if ($urandom_range(0, 1) == 0) req_b = 1'b0;
        else data_b = WIDTH'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        req_b = 1'b0;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
